// File: rtl/trig_delay_gen.sv
// trig_delay_gen: delayed STOP pulse generator for TDC stimulus.
// Optional 4-entry command FIFO enabled by macro TDG_CMD_FIFO_EN.
module trig_delay_gen #(
   parameter int PULSE_WIDTH = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RSTb,
   input  logic       START,
   input  logic [7:0] DELAY,
   input  logic       LOAD,
   output logic       STOP,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR
);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      COUNT,
      PULSE
   } state_e;

   localparam logic [3:0] PW_M1  = 4'(PULSE_WIDTH - 1);
   localparam logic       PW_ONE = (PULSE_WIDTH == 1);

   state_e                 state_q;
   logic [7:0]             cur_q;
   logic [7:0]             cnt_q;
   logic [3:0]             pcnt_q;
   logic                   stop_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   err_q;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] vld_q;
   logic                   prev_q;
   logic                   start_rise;

   logic                   idle;
   logic                   pulse_last;
   logic                   accept;
   logic                   reject;
   logic                   q_vld;
   logic [7:0]             q_dat;

   // START synchronizer; prev resets high so a START held across reset
   // is not mistaken for a rising edge once the chain fills.
   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         sync_q <= '0;
         vld_q  <= '0;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], START};
         vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         if (vld_q[SYNC_STAGES-1]) begin
            prev_q <= sync_q[SYNC_STAGES-1];
         end
      end
   end

   assign start_rise = vld_q[SYNC_STAGES-1]
                     & sync_q[SYNC_STAGES-1]
                     & ~prev_q;

`ifdef TDG_CMD_FIFO_EN
   logic [7:0] fifo_q [4];
   logic [1:0] wr_q;
   logic [1:0] rd_q;
   logic [2:0] fcnt_q;
   logic       push;
   logic       pop;

   // Command acceptance with queueing behind the executing command.
   always_comb begin
      idle       = (state_q == IDLE);
      pulse_last = (state_q == PULSE) && (pcnt_q == 4'd0);
      q_vld      = (fcnt_q != 3'd0);
      q_dat      = fifo_q[rd_q];
      accept     = LOAD && (idle || (fcnt_q != 3'd4) || pulse_last);
      push       = accept && !idle && !(pulse_last && !q_vld);
      pop        = pulse_last && q_vld;
      reject     = LOAD && !accept;
   end

   // Circular command queue storage and pointers.
   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         for (int i = 0; i < 4; i++) begin
            fifo_q[i] <= '0;
         end
         wr_q   <= '0;
         rd_q   <= '0;
         fcnt_q <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_q] <= DELAY;
            wr_q         <= wr_q + 2'd1;
         end
         if (pop) begin
            rd_q <= rd_q + 2'd1;
         end
         fcnt_q <= fcnt_q + 3'(push) - 3'(pop);
      end
   end
`else
   // Single command register: new LOAD only when idle or finishing.
   always_comb begin
      idle       = (state_q == IDLE);
      pulse_last = (state_q == PULSE) && (pcnt_q == 4'd0);
      q_vld      = 1'b0;
      q_dat      = 8'd0;
      accept     = LOAD && (idle || pulse_last);
      reject     = LOAD && !accept;
   end
`endif

   // Main sequencer with registered STOP/BUSY/DONE/ERR.
   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         state_q <= IDLE;
         cur_q   <= '0;
         cnt_q   <= '0;
         pcnt_q  <= '0;
         stop_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q  <= reject;
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  cur_q   <= DELAY;
                  busy_q  <= 1'b1;
                  state_q <= ARMED;
               end
            end
            ARMED: begin
               if (start_rise) begin
                  if (cur_q == 8'd0) begin
                     state_q <= PULSE;
                     stop_q  <= 1'b1;
                     pcnt_q  <= PW_M1;
                     done_q  <= PW_ONE;
                  end else begin
                     state_q <= COUNT;
                     cnt_q   <= cur_q;
                  end
               end
            end
            COUNT: begin
               if (cnt_q == 8'd1) begin
                  state_q <= PULSE;
                  stop_q  <= 1'b1;
                  pcnt_q  <= PW_M1;
                  done_q  <= PW_ONE;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            PULSE: begin
               if (pcnt_q == 4'd0) begin
                  stop_q <= 1'b0;
                  if (q_vld) begin
                     cur_q   <= q_dat;
                     state_q <= ARMED;
                  end else if (accept) begin
                     cur_q   <= DELAY;
                     state_q <= ARMED;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end else begin
                  pcnt_q <= pcnt_q - 4'd1;
                  done_q <= (pcnt_q == 4'd1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign STOP = stop_q;
   assign BUSY = busy_q;
   assign DONE = done_q;
   assign ERR  = err_q;

endmodule

// File: tb/tb_trig_delay_gen.sv
// tb_trig_delay_gen: random and directed bench against a timeline model.
// Command storage depth follows macro TDG_CMD_FIFO_EN.
module tb_trig_delay_gen;

   localparam int PW   = 3;
   localparam int SYNC = 2;
   localparam int HLEN = 32768;
`ifdef TDG_CMD_FIFO_EN
   localparam int CAP = 4;
`else
   localparam int CAP = 0;
`endif

   logic       CLK = 1'b0;
   logic       RSTb;
   logic       START;
   logic [7:0] DELAY;
   logic       LOAD;
   logic       STOP;
   logic       BUSY;
   logic       DONE;
   logic       ERR;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model: pending commands and one active pulse window
   int  q[$];
   bit  act;
   int  st;
   int  en;
   bit  err_pend;
   int  r0;
   bit  h [HLEN];
   bit  s;

   trig_delay_gen #(
      .PULSE_WIDTH(PW),
      .SYNC_STAGES(SYNC)
   ) dut (
      .CLK  (CLK),
      .RSTb (RSTb),
      .START(START),
      .DELAY(DELAY),
      .LOAD (LOAD),
      .STOP (STOP),
      .BUSY (BUSY),
      .DONE (DONE),
      .ERR  (ERR)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d",
                  tag, cyc, got, exp);
      end
   endtask

   task automatic hist(input int c, input bit v);
      if (c >= 0 && c < HLEN) h[c] = v;
   endtask

   function automatic bit hget(input int c);
      if (c >= 0 && c < HLEN) return h[c];
      return 1'b0;
   endfunction

   // one clock cycle: compare, drive, advance the model
   task automatic tick(input bit ld, input logic [7:0] dl,
                       input bit sv);
      int  c;
      bit  sr;
      bit  idle;
      bit  armed;
      bit  last;
      bit  acc;
      int  besides;
      int  d;
      @(negedge CLK);
      c = cyc;
      check("stop", STOP, act && c >= st && c <= en);
      check("done", DONE, act && c == en);
      check("busy", BUSY, act || q.size() > 0);
      check("err",  ERR,  err_pend);
      LOAD  = ld;
      DELAY = dl;
      START = sv;
      hist(c, sv);
      sr = (c - 1 >= r0 + SYNC) && hget(c - SYNC)
           && !hget(c - SYNC - 1);
      idle  = !act && q.size() == 0;
      armed = !act && q.size() > 0;
      if (act) besides = q.size();
      else if (armed) besides = q.size() - 1;
      else besides = 0;
      last = act && c == en;
      acc  = ld && (idle || besides < CAP || last);
      err_pend = ld && !acc;
      if (armed && sr) begin
         d   = q.pop_front();
         act = 1'b1;
         st  = c + 1 + d;
         en  = c + d + PW;
      end
      if (last) act = 1'b0;
      if (acc) q.push_back(int'(dl));
   endtask

   task automatic run(input int n);
      repeat (n) tick(1'b0, 8'd0, s);
   endtask

   task automatic rst_chk(input string tag);
      check({tag, "_stop"}, STOP, 1'b0);
      check({tag, "_busy"}, BUSY, 1'b0);
      check({tag, "_done"}, DONE, 1'b0);
      check({tag, "_err"},  ERR,  1'b0);
   endtask

   task automatic do_reset(input int n);
      @(negedge CLK);
      RSTb = 1'b0;
      LOAD = 1'b0;
      #1;
      rst_chk("rst_async");
      q.delete();
      act = 1'b0;
      err_pend = 1'b0;
      hist(cyc, START);
      repeat (n) begin
         @(negedge CLK);
         rst_chk("rst_hold");
         hist(cyc, START);
      end
      RSTb = 1'b1;
      r0 = cyc;
   endtask

   task automatic wait_win(input int off, input string tag);
      int i;
      i = 0;
      while (!(act && cyc + 1 == st + off) && i < 600) begin
         run(1);
         i++;
      end
      check(tag, i < 600, 1'b1);
   endtask

   initial begin
      RSTb  = 1'b0;
      START = 1'b0;
      LOAD  = 1'b0;
      DELAY = 8'd0;
      s     = 1'b0;
      act   = 1'b0;
      st    = 0;
      en    = 0;
      r0    = 0;
      err_pend = 1'b0;
      do_reset(4);

      // DELAY=0
      tick(1'b1, 8'd0, s);
      run(2);
      s = 1'b1; run(10);
      s = 1'b0; run(3);

      // DELAY=5 with extra START edges during COUNT
      tick(1'b1, 8'd5, s);
      run(2);
      s = 1'b1; run(3);
      s = 1'b0; run(1);
      s = 1'b1; run(12);
      s = 1'b0; run(3);

      // DELAY=255
      tick(1'b1, 8'd255, s);
      run(2);
      s = 1'b1; run(270);
      s = 1'b0; run(3);

      // LOAD while busy
      tick(1'b1, 8'd7, s);
      run(1);
      tick(1'b1, 8'd3, s);
      s = 1'b1; run(3);
      tick(1'b1, 8'd9, s);
      run(20);
      s = 1'b0; run(3);
      s = 1'b1; run(20);
      s = 1'b0; run(3);

      // LOAD in the DONE cycle
      tick(1'b1, 8'd4, s);
      s = 1'b1; run(2);
      wait_win(PW - 1, "win_done");
      tick(1'b1, 8'd6, s);
      s = 1'b0; run(2);
      s = 1'b1; run(15);
      s = 1'b0; run(3);

      // back-to-back LOADs 1..6
      for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i), s);
      run(2);
      repeat (6) begin
         s = 1'b1; run(4);
         s = 1'b0; run(16);
      end

      // reset in the middle of PULSE, START held high
      tick(1'b1, 8'd2, s);
      s = 1'b1; run(1);
      wait_win(1, "win_pulse");
      do_reset(3);
      run(5);
      tick(1'b1, 8'd2, s);
      run(8);
      s = 1'b0; run(3);
      s = 1'b1; run(10);
      s = 1'b0; run(3);

      // START held high across LOAD
      s = 1'b1; run(4);
      tick(1'b1, 8'd3, s);
      run(10);
      s = 1'b0; run(3);
      s = 1'b1; run(12);
      s = 1'b0; run(3);

      // randomized traffic
      for (int i = 0; i < 5000; i++) begin
         bit         ld;
         logic [7:0] dl;
         ld = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 31) == 0) dl = 8'd255;
         else dl = 8'($urandom_range(0, 12));
         if ($urandom_range(0, 5) == 0) s = ~s;
         if ($urandom_range(0, 1499) == 0) begin
            do_reset(2);
         end else begin
            tick(ld, dl, s);
         end
      end
      s = 1'b0; run(300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
